// File: rtl/oserdes_7to1_tx.sv
// 7:1 fabric DDR serializer: two 7-bit words per 7-cycle frame onto an ODDR data pin,
// plus a 4:3-duty forwarded pixel clock at fclk/3.5 for a second ODDR pin.
module oserdes_7to1_tx #(
    parameter logic [6:0] IDLE_WORD = 7'b1100011,
    parameter int         CNT_W     = 8
) (
    input  logic             fclk_i,
    input  logic             rst,
    input  logic [6:0]       data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             d_rise_o,
    output logic             d_fall_o,
    output logic             clk_rise_o,
    output logic             clk_fall_o,
    output logic             load_o,
    output logic             underflow_o,
    output logic [CNT_W-1:0] underflow_cnt_o
);

    typedef enum logic [2:0] {
        PH0 = 3'd0, PH1 = 3'd1, PH2 = 3'd2, PH3 = 3'd3,
        PH4 = 3'd4, PH5 = 3'd5, PH6 = 3'd6
    } ph_t;

    ph_t        ph;
    ph_t        ph_nxt;
    logic [6:0] hold;
    logic       hv;
    logic [6:0] word;
    logic [6:0] next_word;
    logic       load_event;
    logic       xfer;

    // Word A is loaded on the 6->0 edge, word B on the 2->3 edge.
    assign load_event = (ph == PH6) || (ph == PH2);
    // A load frees the hold register in the same cycle, so the source may refill it with no bubble.
    assign ready_o    = rst && (!hv || load_event);
    assign xfer       = valid_i && ready_o;
    assign next_word  = hv ? hold : IDLE_WORD;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        ph_nxt = PH0;
        if (ph != PH6) begin
            ph_nxt = ph_t'(ph + 3'd1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so the old word is still visible
    // on the ph2->3 edge where A6 and B0 share one output cycle.
    always_ff @(posedge fclk_i) begin
        if (!rst) begin
            ph              <= PH6;
            hv              <= 1'b0;
            word            <= '0;
            d_rise_o        <= 1'b0;
            d_fall_o        <= 1'b0;
            clk_rise_o      <= 1'b0;
            clk_fall_o      <= 1'b0;
            load_o          <= 1'b0;
            underflow_o     <= 1'b0;
            underflow_cnt_o <= '0;
        end else begin
            ph          <= ph_nxt;
            load_o      <= load_event;
            underflow_o <= load_event && !hv;

            if (xfer) begin
                hv <= 1'b1;
            end else if (load_event) begin
                hv <= 1'b0;
            end

            if (load_event) begin
                word <= next_word;
            end

            if (load_event && !hv && (underflow_cnt_o != {CNT_W{1'b1}})) begin
                underflow_cnt_o <= underflow_cnt_o + 1'b1;
            end

            case (ph_nxt)
                PH0: begin
                    d_rise_o <= next_word[0];
                    d_fall_o <= next_word[1];
                    {clk_rise_o, clk_fall_o} <= 2'b11;
                end
                PH1: begin
                    d_rise_o <= word[2];
                    d_fall_o <= word[3];
                    {clk_rise_o, clk_fall_o} <= 2'b11;
                end
                PH2: begin
                    d_rise_o <= word[4];
                    d_fall_o <= word[5];
                    {clk_rise_o, clk_fall_o} <= 2'b00;
                end
                PH3: begin
                    d_rise_o <= word[6];
                    d_fall_o <= next_word[0];
                    {clk_rise_o, clk_fall_o} <= 2'b01;
                end
                PH4: begin
                    d_rise_o <= word[1];
                    d_fall_o <= word[2];
                    {clk_rise_o, clk_fall_o} <= 2'b11;
                end
                PH5: begin
                    d_rise_o <= word[3];
                    d_fall_o <= word[4];
                    {clk_rise_o, clk_fall_o} <= 2'b10;
                end
                default: begin
                    d_rise_o <= word[5];
                    d_fall_o <= word[6];
                    {clk_rise_o, clk_fall_o} <= 2'b00;
                end
            endcase
        end
    end

    // NOTE: the hold data register has no reset; hv alone says whether its contents mean anything.
    always_ff @(posedge fclk_i) begin
        if (xfer) begin
            hold <= data_i;
        end
    end

endmodule
